// File: rtl/chord_song_reader.sv
// Song sequencer: walks a song ROM entry by entry, hands note entries to the chord
// player one load strobe at a time, and stalls on wait entries for a number of beats.
module chord_song_reader #(
    parameter int SONG_BITS  = 2,
    parameter int ENTRY_BITS = 5
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            play_enable,
    input  logic [SONG_BITS-1:0]            song,
    input  logic                            beat,
    input  logic                            note_done,
    output logic [SONG_BITS+ENTRY_BITS-1:0] rom_addr,
    input  logic [15:0]                     rom_data,
    output logic [5:0]                      note_to_load,
    output logic [5:0]                      duration,
    output logic                            load_new_note,
    output logic                            activate,
    output logic                            song_done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        ISSUE,
        WAIT,
        NEXT,
        DONE
    } state_t;

    localparam logic [ENTRY_BITS-1:0] ENTRY_LAST = '1;

    state_t                  state_q, state_d;
    logic [ENTRY_BITS-1:0]   entry_q, entry_d;
    logic [SONG_BITS-1:0]    song_q, song_d;
    logic [5:0]              wait_q, wait_d;
    logic [5:0]              note_q, note_d;
    logic [5:0]              dur_q, dur_d;
    logic                    act_q, act_d;
    logic                    loadNote;
    logic                    songChange;
    logic                    isEndMarker;
    logic                    isWaitEntry;
    logic                    unusedEntryBits;

    assign songChange      = (song != song_q);
    assign isEndMarker     = (rom_data == 16'h0000);
    assign isWaitEntry     = rom_data[15];
    assign unusedEntryBits = ^rom_data[2:1];

    // A song change restarts the sequence and outranks everything, including the
    // freeze from play_enable and a load strobe that would otherwise fire now.
    always_comb begin
        state_d  = state_q;
        entry_d  = entry_q;
        song_d   = song_q;
        wait_d   = wait_q;
        note_d   = note_q;
        dur_d    = dur_q;
        act_d    = act_q;
        loadNote = 1'b0;

        if (songChange) begin
            song_d  = song;
            entry_d = '0;
            wait_d  = '0;
            state_d = FETCH;
        end else if (play_enable) begin
            case (state_q)
                IDLE: begin
                    state_d = FETCH;
                end
                FETCH: begin
                    state_d = DECODE;
                end
                DECODE: begin
                    if (isEndMarker) begin
                        state_d = DONE;
                    end else if (!isWaitEntry) begin
                        note_d  = rom_data[14:9];
                        dur_d   = rom_data[8:3];
                        act_d   = rom_data[0];
                        state_d = ISSUE;
                    end else if (rom_data[5:0] == 6'd0) begin
                        state_d = NEXT;
                    end else begin
                        wait_d  = rom_data[5:0];
                        state_d = WAIT;
                    end
                end
                ISSUE: begin
                    if (note_done) begin
                        loadNote = 1'b1;
                        state_d  = NEXT;
                    end
                end
                WAIT: begin
                    if (beat) begin
                        if (wait_q <= 6'd1) begin
                            wait_d  = 6'd0;
                            state_d = NEXT;
                        end else begin
                            wait_d = wait_q - 6'd1;
                        end
                    end
                end
                NEXT: begin
                    // The last entry of a song never wraps back to entry 0.
                    if (entry_q == ENTRY_LAST) begin
                        state_d = DONE;
                    end else begin
                        entry_d = entry_q + 1'b1;
                        state_d = FETCH;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            entry_q <= '0;
            song_q  <= '0;
            wait_q  <= '0;
            note_q  <= '0;
            dur_q   <= '0;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            song_q  <= song_d;
            wait_q  <= wait_d;
            note_q  <= note_d;
            dur_q   <= dur_d;
            act_q   <= act_d;
        end
    end

    assign rom_addr      = {song_q, entry_q};
    assign note_to_load  = note_q;
    assign duration      = dur_q;
    assign activate      = act_q;
    assign load_new_note = loadNote;
    assign song_done     = (state_q == DONE);

endmodule

// File: tb/tb_chord_song_reader.sv
// Bench for chord_song_reader: a behavioural ROM, a queue of expected note loads
// checked by an independent monitor, and directed song scenarios.
module tb_chord_song_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        play_enable;
    logic [1:0]  song;
    logic        beat;
    logic        note_done;
    logic [6:0]  rom_addr;
    logic [15:0] rom_data;
    logic [5:0]  note_to_load;
    logic [5:0]  duration;
    logic        load_new_note;
    logic        activate;
    logic        song_done;

    logic [15:0] rom [0:127];
    logic [12:0] expQ [$];
    int          checks = 0;
    int          errors = 0;
    int          pulseCount = 0;
    int          lastPulseCyc = 0;
    int          cyc = 0;

    chord_song_reader #(.SONG_BITS(2), .ENTRY_BITS(5)) dut (
        .clk(clk),
        .reset(reset),
        .play_enable(play_enable),
        .song(song),
        .beat(beat),
        .note_done(note_done),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .note_to_load(note_to_load),
        .duration(duration),
        .load_new_note(load_new_note),
        .activate(activate),
        .song_done(song_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Synchronous ROM: data follows the address by one clock.
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Every load strobe must match the oldest expected note in the queue.
    always @(negedge clk) begin
        logic [12:0] got;
        logic [12:0] want;
        if (!reset && load_new_note) begin
            pulseCount++;
            lastPulseCyc = cyc;
            got = {note_to_load, duration, activate};
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL pulse unexpected: got note=%0d dur=%0d act=%0d, required no pulse",
                         got[12:7], got[6:1], got[0]);
            end else begin
                want = expQ.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("[TB] FAIL pulse contents: got note=%0d dur=%0d act=%0d, required note=%0d dur=%0d act=%0d",
                             got[12:7], got[6:1], got[0], want[12:7], want[6:1], want[0]);
                end
            end
        end
    end

    function automatic logic [15:0] noteEntry(input int n, input int d, input bit a);
        return {1'b0, 6'(n), 6'(d), 2'b00, a};
    endfunction

    function automatic logic [15:0] waitEntry(input int c);
        return {1'b1, 9'd0, 6'(c)};
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    task automatic pushNote(input int n, input int d, input bit a);
        expQ.push_back({6'(n), 6'(d), a});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic applyStimulus(input bit en, input bit nd);
        play_enable = en;
        note_done   = nd;
    endtask

    task automatic pulseBeat();
        beat = 1'b1;
        tick();
        beat = 1'b0;
    endtask

    task automatic clearRom();
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    endtask

    task automatic applyReset(input string name);
        reset       = 1'b1;
        play_enable = 1'b0;
        note_done   = 1'b0;
        beat        = 1'b0;
        song        = 2'd0;
        cycles(2);
        checkOutput({name, " reset rom_addr"}, rom_addr, 0);
        checkOutput({name, " reset outputs"},
                    {note_to_load, duration, load_new_note, activate, song_done}, 0);
        reset = 1'b0;
        tick();
    endtask

    task automatic waitPulses(input int target, input int budget, input string name);
        int n = 0;
        while (pulseCount < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput(name, pulseCount, target);
    endtask

    task automatic waitDone(input int budget, input string name);
        int n = 0;
        while (!song_done && n < budget) begin
            tick();
            n++;
        end
        checkOutput(name, song_done, 1);
    endtask

    initial begin
        int base;
        int beatCyc;
        int bad;

        beat = 1'b0;
        clearRom();

        // Single note followed by the end marker.
        rom[0] = noteEntry(20, 12, 0);
        applyReset("t1");
        base = pulseCount;
        pushNote(20, 12, 0);
        applyStimulus(1, 1);
        waitPulses(base + 1, 20, "t1 pulse count");
        waitDone(20, "t1 song_done");
        checkOutput("t1 rom_addr at end", rom_addr, 1);
        cycles(6);
        checkOutput("t1 rom_addr holds", rom_addr, 1);
        checkOutput("t1 no extra pulses", pulseCount, base + 1);

        // Wait of three beats, then a note four cycles after the last beat.
        clearRom();
        rom[0] = waitEntry(3);
        rom[1] = noteEntry(5, 1, 0);
        applyReset("t2");
        base = pulseCount;
        applyStimulus(1, 1);
        for (int b = 0; b < 2; b++) begin
            cycles(9);
            pulseBeat();
        end
        cycles(9);
        checkOutput("t2 no pulse before beat 3", pulseCount, base);
        pushNote(5, 1, 0);
        beatCyc = cyc;
        pulseBeat();
        waitPulses(base + 1, 20, "t2 pulse count");
        checkOutput("t2 beat to pulse latency", lastPulseCyc - beatCyc, 4);
        waitDone(20, "t2 song_done");

        // Player busy for 50 cycles: no strobe, note held steady.
        clearRom();
        rom[0] = noteEntry(33, 7, 1);
        applyReset("t3");
        base = pulseCount;
        applyStimulus(1, 0);
        cycles(5);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (load_new_note || note_to_load != 6'd33 || duration != 6'd7) bad++;
        end
        checkOutput("t3 held cycles with bad outputs", bad, 0);
        pushNote(33, 7, 1);
        note_done = 1'b1;
        waitPulses(base + 1, 10, "t3 pulse count");
        waitDone(20, "t3 song_done");
        checkOutput("t3 single pulse", pulseCount, base + 1);

        // Freeze in WAIT with two beats left; frozen beats are dropped.
        clearRom();
        rom[0] = waitEntry(4);
        rom[1] = noteEntry(9, 3, 0);
        applyReset("t4");
        base = pulseCount;
        applyStimulus(1, 1);
        cycles(4);
        pulseBeat();
        cycles(3);
        pulseBeat();
        cycles(3);
        play_enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pulseBeat();
            cycles(2);
        end
        checkOutput("t4 rom_addr frozen", rom_addr, 0);
        checkOutput("t4 no pulse while frozen", pulseCount, base);
        play_enable = 1'b1;
        cycles(2);
        pulseBeat();
        cycles(8);
        checkOutput("t4 still waiting after one beat", rom_addr, 0);
        pushNote(9, 3, 0);
        pulseBeat();
        waitPulses(base + 1, 20, "t4 pulse count");
        checkOutput("t4 rom_addr after wait", rom_addr, 1);
        waitDone(20, "t4 song_done");

        // A full song of 32 notes with no end marker.
        clearRom();
        for (int i = 0; i < 32; i++) begin
            rom[i] = noteEntry(i + 1, i + 2, i[0]);
        end
        applyReset("t5");
        base = pulseCount;
        for (int i = 0; i < 32; i++) pushNote(i + 1, i + 2, i[0]);
        applyStimulus(1, 1);
        waitPulses(base + 32, 200, "t5 pulse count");
        waitDone(20, "t5 song_done");
        checkOutput("t5 rom_addr no wrap", rom_addr, 31);
        cycles(6);
        checkOutput("t5 rom_addr stays", rom_addr, 31);
        checkOutput("t5 no extra pulses", pulseCount, base + 32);

        // Song switch during ISSUE suppresses the pending strobe.
        clearRom();
        rom[0]  = noteEntry(10, 2, 0);
        rom[64] = noteEntry(40, 5, 1);
        applyReset("t6a");
        base = pulseCount;
        applyStimulus(1, 0);
        cycles(5);
        checkOutput("t6a note in ISSUE", note_to_load, 10);
        pushNote(40, 5, 1);
        song      = 2'd2;
        note_done = 1'b1;
        tick();
        checkOutput("t6a rom_addr after switch", rom_addr, 64);
        checkOutput("t6a song_done after switch", song_done, 0);
        checkOutput("t6a no pulse on switch", pulseCount, base);
        waitPulses(base + 1, 20, "t6a pulse count");
        waitDone(20, "t6a song_done");
        checkOutput("t6a rom_addr at end", rom_addr, 65);
        pushNote(10, 2, 0);
        song = 2'd0;
        tick();
        checkOutput("t6a restart from DONE song_done", song_done, 0);
        checkOutput("t6a restart rom_addr", rom_addr, 0);
        waitPulses(base + 2, 20, "t6a restart pulse count");
        waitDone(20, "t6a restart song_done");

        // Asynchronous reset in the middle of a wait.
        clearRom();
        rom[0] = noteEntry(11, 4, 1);
        rom[1] = waitEntry(5);
        applyReset("t6b");
        base = pulseCount;
        pushNote(11, 4, 1);
        applyStimulus(1, 1);
        waitPulses(base + 1, 20, "t6b first pulse");
        cycles(4);
        checkOutput("t6b in wait rom_addr", rom_addr, 1);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("t6b async reset rom_addr", rom_addr, 0);
        checkOutput("t6b async reset outputs",
                    {note_to_load, duration, load_new_note, activate, song_done}, 0);
        play_enable = 1'b0;
        cycles(2);
        reset = 1'b0;
        cycles(5);
        checkOutput("t6b idle no pulse", pulseCount, base + 1);
        checkOutput("t6b idle rom_addr", rom_addr, 0);
        pushNote(11, 4, 1);
        play_enable = 1'b1;
        waitPulses(base + 2, 20, "t6b restart pulse");

        checkOutput("expected queue drained", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
